// File: rtl/ahb_bm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_bm_pkg
//  Brief    : Shared AHB encodings, field widths and the address-phase bundle
//             used by the bus-matrix input stage.
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_bm_pkg;

    // Field widths of the master address phase
    localparam int c_ADDR_W   = 32;
    localparam int c_USER_W   = 32;
    localparam int c_TRANS_W  = 2;
    localparam int c_SIZE_W   = 3;
    localparam int c_BURST_W  = 3;
    localparam int c_PROT_W   = 4;
    localparam int c_MASTER_W = 4;
    localparam int c_RESP_W   = 2;

    // HTRANS encodings
    localparam logic [c_TRANS_W-1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [c_TRANS_W-1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [c_TRANS_W-1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [c_TRANS_W-1:0] c_HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic [c_RESP_W-1:0] c_HRESP_OKAY  = 2'b00;
    localparam logic [c_RESP_W-1:0] c_HRESP_ERROR = 2'b01;

    // Address/control fields of one transfer (user bits kept separately so
    // they can be compiled out)
    typedef struct packed {
        logic [c_ADDR_W-1:0]   addr;
        logic [c_TRANS_W-1:0]  trans;
        logic                  write;
        logic [c_SIZE_W-1:0]   size;
        logic [c_BURST_W-1:0]  burst;
        logic [c_PROT_W-1:0]   prot;
        logic [c_MASTER_W-1:0] master;
        logic                  mastlock;
    } ahb_addr_ctrl_t;

endpackage : ahb_bm_pkg
`default_nettype wire

// File: rtl/ahb_bm_input_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_bm_input_stage
//  Brief    : AHB bus-matrix input stage. Presents the master address phase
//             to the decoder/output stages, holding it in a register and
//             inserting wait states while the addressed output stage has not
//             yet accepted it. Tracks the data phase to route ready/response.
//  Options  : AHB_BM_INPUT_USER_EN - hold and forward HAUSERS on auser_ip;
//             when undefined auser_ip is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_bm_input_stage
    import ahb_bm_pkg::*;
(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    // Master address phase
    input  logic                  HSELS,
    input  logic [c_ADDR_W-1:0]   HADDRS,
    input  logic [c_TRANS_W-1:0]  HTRANSS,
    input  logic                  HWRITES,
    input  logic [c_SIZE_W-1:0]   HSIZES,
    input  logic [c_BURST_W-1:0]  HBURSTS,
    input  logic [c_PROT_W-1:0]   HPROTS,
    input  logic [c_MASTER_W-1:0] HMASTERS,
    input  logic                  HMASTLOCKS,
    input  logic [c_USER_W-1:0]   HAUSERS,
    input  logic                  HREADYS,
    // Response to master
    output logic                  HREADYOUTS,
    output logic [c_RESP_W-1:0]   HRESPS,
    // Address phase to decoder / output stages
    output logic                  sel_ip,
    output logic [c_ADDR_W-1:0]   addr_ip,
    output logic [c_USER_W-1:0]   auser_ip,
    output logic [c_TRANS_W-1:0]  trans_ip,
    output logic                  write_ip,
    output logic [c_SIZE_W-1:0]   size_ip,
    output logic [c_BURST_W-1:0]  burst_ip,
    output logic [c_PROT_W-1:0]   prot_ip,
    output logic [c_MASTER_W-1:0] master_ip,
    output logic                  mastlock_ip,
    output logic                  held_tran_ip,
    // Feedback from the addressed output stage
    input  logic                  active_ip,
    input  logic                  readyout_ip,
    input  logic [c_RESP_W-1:0]   resp_ip
);

    logic           r_pend_tran;
    logic           r_data_phase;
    ahb_addr_ctrl_t r_hold;
    ahb_addr_ctrl_t w_live;
    ahb_addr_ctrl_t w_sel;
    logic           w_trans_valid;
    logic           w_held;
    logic           w_accept;
    logic           w_capture;

    assign w_live = '{addr: HADDRS, trans: HTRANSS, write: HWRITES,
                      size: HSIZES, burst: HBURSTS, prot: HPROTS,
                      master: HMASTERS, mastlock: HMASTLOCKS};

    assign w_trans_valid = HSELS & HREADYS & HTRANSS[1];
    assign w_held        = r_pend_tran | w_trans_valid;
    assign w_accept      = w_held & active_ip & readyout_ip;
    // While a transfer is pending HREADYOUTS is low, so new bus fields are
    // not a real transfer and must not overwrite the held one.
    assign w_capture     = w_trans_valid & ~w_accept & ~r_pend_tran;

    // Pending flag and data-phase tracking
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend_tran  <= 1'b0;
            r_data_phase <= 1'b0;
        end else begin
            if (w_accept)
                r_pend_tran <= 1'b0;
            else if (w_capture)
                r_pend_tran <= 1'b1;

            if (w_accept)
                r_data_phase <= 1'b1;
            else if (readyout_ip)
                r_data_phase <= 1'b0;
        end
    end

    // Holding register for a transfer not accepted on arrival
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_hold <= '0;
        else if (w_capture)
            r_hold <= w_live;
    end

`ifdef AHB_BM_INPUT_USER_EN
    logic [c_USER_W-1:0] r_hold_auser;

    // User bits travel with the held address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_hold_auser <= '0;
        else if (w_capture)
            r_hold_auser <= HAUSERS;
    end

    assign auser_ip = r_pend_tran ? r_hold_auser : HAUSERS;
`else
    logic w_unused_auser;
    assign w_unused_auser = ^HAUSERS;
    assign auser_ip       = '0;
`endif

    // Address-phase mux: held copy while pending, otherwise the live bus
    always_comb begin
        w_sel  = r_pend_tran ? r_hold : w_live;
        sel_ip = r_pend_tran ? 1'b1 : (HSELS & HREADYS);
    end

    assign addr_ip      = w_sel.addr;
    assign trans_ip     = w_sel.trans;
    assign write_ip     = w_sel.write;
    assign size_ip      = w_sel.size;
    assign burst_ip     = w_sel.burst;
    assign prot_ip      = w_sel.prot;
    assign master_ip    = w_sel.master;
    assign mastlock_ip  = w_sel.mastlock;
    assign held_tran_ip = w_held;

    // Ready and response returned to the master
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = c_HRESP_OKAY;
        if (r_pend_tran)
            HREADYOUTS = 1'b0;
        else if (r_data_phase)
            HREADYOUTS = readyout_ip;
        if (r_data_phase)
            HRESPS = resp_ip;
    end

endmodule : ahb_bm_input_stage
`default_nettype wire

// File: tb/tb_ahb_bm_input_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_bm_input_stage
//  Brief    : Self-checking bench for ahb_bm_input_stage. Every transfer the
//             master issues is queued with its expected fields and checked
//             when the output stage accepts it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_bm_input_stage;
    import ahb_bm_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic [31:0] HAUSERS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_ip;
    logic [31:0] addr_ip;
    logic [31:0] auser_ip;
    logic [1:0]  trans_ip;
    logic        write_ip;
    logic [2:0]  size_ip;
    logic [2:0]  burst_ip;
    logic [3:0]  prot_ip;
    logic [3:0]  master_ip;
    logic        mastlock_ip;
    logic        held_tran_ip;
    logic        active_ip;
    logic        readyout_ip;
    logic [1:0]  resp_ip;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [3:0]  master;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

`ifdef AHB_BM_INPUT_USER_EN
    localparam logic [31:0] c_USER_EXP = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] c_USER_EXP = 32'h0;
`endif

    always #5 HCLK = ~HCLK;

    ahb_bm_input_stage dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
        .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
        .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip),
        .trans_ip(trans_ip), .write_ip(write_ip), .size_ip(size_ip),
        .burst_ip(burst_ip), .prot_ip(prot_ip), .master_ip(master_ip),
        .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
        .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip)
    );

    // Scoreboard: each accept seen by the output stage pops one expectation
    always @(negedge HCLK) begin
        if (HRESETn && held_tran_ip && active_ip && readyout_ip) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: accept of addr %h, no transfer expected", addr_ip);
            end else begin
                sb_e = sb_q.pop_front();
                if (addr_ip !== sb_e.addr || trans_ip !== sb_e.trans ||
                    write_ip !== sb_e.write || master_ip !== sb_e.master) begin
                    n_err++;
                    $display("FAIL sb_accept: got addr %h trans %b wr %b mst %h, exp addr %h trans %b wr %b mst %h",
                             addr_ip, trans_ip, write_ip, master_ip,
                             sb_e.addr, sb_e.trans, sb_e.write, sb_e.master);
                end
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_idle();
        HSELS = 1'b0; HADDRS = '0; HTRANSS = c_HTRANS_IDLE; HWRITES = 1'b0;
        HSIZES = '0; HBURSTS = '0; HPROTS = '0; HMASTERS = '0;
        HMASTLOCKS = 1'b0; HAUSERS = '0; HREADYS = 1'b1;
        active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = c_HRESP_OKAY;
    endtask

    task automatic drive_xfer(input logic [31:0] a, input logic [1:0] t,
                              input logic w, input logic [31:0] u, input bit issue);
        HSELS = 1'b1; HREADYS = 1'b1; HADDRS = a; HTRANSS = t; HWRITES = w;
        HSIZES = 3'd2; HBURSTS = 3'd1; HPROTS = 4'h3; HMASTERS = 4'h5;
        HMASTLOCKS = 1'b0; HAUSERS = u;
        if (issue)
            sb_q.push_back('{addr: a, trans: t, write: w, master: 4'h5});
    endtask

    task automatic test_reset();
        set_idle();
        HRESETn = 1'b0;
        HSELS = 1'b1; HADDRS = 32'h0000_1234;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rst_hreadyout: got %b exp 1", HREADYOUTS); end
        n_cmp++; if (HRESPS !== c_HRESP_OKAY) begin n_err++; $display("FAIL rst_hresp: got %b exp 00", HRESPS); end
        n_cmp++; if (held_tran_ip !== 1'b0) begin n_err++; $display("FAIL rst_held: got %b exp 0", held_tran_ip); end
        n_cmp++; if (addr_ip !== 32'h0000_1234) begin n_err++; $display("FAIL rst_addr_live: got %h exp 00001234", addr_ip); end
        n_cmp++; if (sel_ip !== 1'b1) begin n_err++; $display("FAIL rst_sel_live: got %b exp 1", sel_ip); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        set_idle();
        step();
    endtask

    task automatic test_zero_latency();
        drive_xfer(32'h2000_0000, c_HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
        active_ip = 1'b1; readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (held_tran_ip !== 1'b1) begin n_err++; $display("FAIL zl_held: got %b exp 1", held_tran_ip); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL zl_ready_addr: got %b exp 1", HREADYOUTS); end
        step();
        set_idle(); readyout_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL zl_ready_follow0: got %b exp 0", HREADYOUTS); end
        n_cmp++; if (held_tran_ip !== 1'b0) begin n_err++; $display("FAIL zl_no_capture: got %b exp 0", held_tran_ip); end
        step();
        readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL zl_ready_follow1: got %b exp 1", HREADYOUTS); end
        step();
        readyout_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL zl_dphase_end: got %b exp 1", HREADYOUTS); end
        step();
        set_idle();
    endtask

    task automatic test_wait_states();
        drive_xfer(32'h4000_0010, c_HTRANS_NONSEQ, 1'b0, 32'h0, 1'b1);
        active_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL ws_ready_arrive: got %b exp 1", HREADYOUTS); end
        for (int i = 1; i <= 3; i++) begin
            step();
            HREADYS = 1'b0;
            HADDRS  = 32'h5000_0000 + i;
            HTRANSS = c_HTRANS_SEQ;
            active_ip = (i == 3);
            @(negedge HCLK);
            n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL ws_ready cyc%0d: got %b exp 0", i, HREADYOUTS); end
            n_cmp++; if (addr_ip !== 32'h4000_0010) begin n_err++; $display("FAIL ws_addr_hold cyc%0d: got %h exp 40000010", i, addr_ip); end
            n_cmp++; if (trans_ip !== c_HTRANS_NONSEQ || sel_ip !== 1'b1) begin n_err++; $display("FAIL ws_ctrl_hold cyc%0d: got trans %b sel %b exp 10 1", i, trans_ip, sel_ip); end
        end
        step();
        set_idle();
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin n_err++; $display("FAIL ws_done: got ready %b held %b exp 1 0", HREADYOUTS, held_tran_ip); end
        step();
    endtask

    task automatic test_error_resp();
        drive_xfer(32'h3000_0000, c_HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
        active_ip = 1'b0;
        step();
        HREADYS = 1'b0; active_ip = 1'b1; readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b0 || addr_ip !== 32'h3000_0000) begin n_err++; $display("FAIL er_pend: got ready %b addr %h exp 0 30000000", HREADYOUTS, addr_ip); end
        step();
        set_idle(); readyout_ip = 1'b0; resp_ip = c_HRESP_ERROR;
        @(negedge HCLK);
        n_cmp++; if (HRESPS !== c_HRESP_ERROR || HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL er_cycle1: got resp %b ready %b exp 01 0", HRESPS, HREADYOUTS); end
        step();
        readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (HRESPS !== c_HRESP_ERROR || HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL er_cycle2: got resp %b ready %b exp 01 1", HRESPS, HREADYOUTS); end
        step();
        set_idle();
        @(negedge HCLK);
        n_cmp++; if (HRESPS !== c_HRESP_OKAY) begin n_err++; $display("FAIL er_after: got resp %b exp 00", HRESPS); end
        step();
    endtask

    task automatic test_back_to_back();
        drive_xfer(32'h0000_0100, c_HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
        active_ip = 1'b1; readyout_ip = 1'b1;
        step();
        drive_xfer(32'h0000_0104, c_HTRANS_SEQ, 1'b1, 32'h0, 1'b1);
        active_ip = 1'b1; readyout_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got %b exp 0", HREADYOUTS); end
        step();
        HREADYS = 1'b0; readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (addr_ip !== 32'h0000_0104 || trans_ip !== c_HTRANS_SEQ) begin n_err++; $display("FAIL b2b_held_beat2: got addr %h trans %b exp 00000104 11", addr_ip, trans_ip); end
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL b2b_wait: got %b exp 0", HREADYOUTS); end
        step();
        set_idle();
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b exp 1", HREADYOUTS); end
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL b2b_lost: got %0d outstanding exp 0", sb_q.size()); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        drive_xfer(32'h6000_0000, c_HTRANS_NONSEQ, 1'b0, 32'h0, 1'b0);
        active_ip = 1'b0;
        step();
        HREADYS = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL rmw_pending: got %b exp 0", HREADYOUTS); end
        HRESETn = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin n_err++; $display("FAIL rmw_async: got ready %b held %b exp 1 0", HREADYOUTS, held_tran_ip); end
        step();
        set_idle();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            active_ip = 1'b1; readyout_ip = 1'b1;
            @(negedge HCLK);
            n_cmp++; if (held_tran_ip !== 1'b0 || HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rmw_after cyc%0d: got held %b ready %b exp 0 1", i, held_tran_ip, HREADYOUTS); end
            step();
        end
        set_idle();
    endtask

    task automatic test_user();
        drive_xfer(32'h7000_0000, c_HTRANS_NONSEQ, 1'b1, 32'hDEAD_BEEF, 1'b1);
        active_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (auser_ip !== c_USER_EXP) begin n_err++; $display("FAIL user_live: got %h exp %h", auser_ip, c_USER_EXP); end
        step();
        HREADYS = 1'b0; HAUSERS = 32'h1111_1111; active_ip = 1'b1; readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (auser_ip !== c_USER_EXP) begin n_err++; $display("FAIL user_held: got %h exp %h", auser_ip, c_USER_EXP); end
        step();
        set_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_wait_states();
        test_error_resp();
        test_back_to_back();
        test_reset_mid_wait();
        test_user();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d outstanding exp 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ahb_bm_input_stage
`default_nettype wire
